run_pattern_gen: RTL
====================

# run_pattern_gen

Serial test-pattern transmitter that drives the single-bit `w` stream consumed by the run-of-four sequence detector. A parallel pattern word, with a bit length and repeat count, is loaded under a start/busy/done handshake and shifted out LSB-first, one bit per enabled clock. The block also produces `expect_z`, a cycle-aligned prediction of the detector's `z` output, so a detector can be checked in-system against the generator.

## Interface
- `WIDTH`, default 16: maximum pattern length in bits.
- `REPEAT_W`, default 4: width of the repeat count.
- `LEN_W`, default `$clog2(WIDTH+1)`: width of the length field (derived; not overridden).
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: one clock; reset is synchronous and active-high; overrides `enable`.
- `enable`  in  1: clock enable; when 0, all state, counters and outputs hold.
- `start`  in  1: request a transfer; sampled only in IDLE with `enable`=1.
- `pattern`  in  WIDTH: bits to send, bit 0 first; latched at start.
- `length`  in  LEN_W: bits per pass, 0..WIDTH; latched at start; values >WIDTH are clamped to WIDTH.
- `repeat_n`  in  REPEAT_W: extra passes; total bits = length*(repeat_n+1).
- `w`  out  1: serial data to the detector, registered.
- `w_valid`  out  1: `w` carries a pattern bit this cycle.
- `busy`  out  1: transfer in progress (SHIFT state).
- `done`  out  1: high for the single DONE-state cycle.
- `expect_z`  out  1: predicted detector `z`, registered.

## Operation
- States: IDLE, SHIFT, DONE. All transitions require `enable`=1.
- IDLE: `busy`, `w`, `w_valid`, `done`, `expect_z` = 0.
  - `start`=1, length>0: latch inputs, idx=0, rep=repeat_n, clear predictor, go to SHIFT.
  - `start`=1, length=0: go directly to DONE; no bits are sent.
- SHIFT: `w`=pattern[idx], `w_valid`=1, `busy`=1.
  - idx<len-1: idx++.
  - idx=len-1, rep>0: rep--, idx=0.
  - idx=len-1, rep=0: go to DONE.
- DONE: `done`=1, `w`=0, `w_valid`=0, `busy`=0. Next enabled cycle goes to IDLE.
- `start` is ignored outside IDLE; pattern, length and repeat_n changes after latching have no effect.
- Predictor:
  - 4-bit history of sent bits plus a saturating count (0..4), both cleared at start.
  - `expect_z` in cycle c = (count==4) && (history all-1s or all-0s) over bits sent in cycles < c.
  - Valid in SHIFT and DONE; 0 in IDLE.
  - A run of 4 or more equal bits keeps `expect_z` high, matching the detector's self-loop on a fifth and later equal bit.
- Reset (any state, including mid-SHIFT): next cycle is IDLE with all outputs 0, counters and history cleared.

## Timing
- `start` sampled at edge ending cycle N; bit k (0-based) is on `w` in cycle N+1+k while `enable` stays high.
- `done` is in cycle N+1+total; `busy` is high in cycles N+1..N+total.
- `expect_z` lags `w` by one cycle, the same latency as the detector's Moore `z`.
- `enable`=0 stretches every cycle one for one; no bit is skipped or duplicated on `w` when `w_valid` is sampled with `enable`.
- Back-to-back transfers: earliest next `start` is in the cycle after DONE, i.e. in IDLE.

## Structure
- Package `run_gen_pkg`: state enum `gen_state_t` {IDLE, SHIFT, DONE} and constant `RUN_LEN`=4.
- Sub-module `run_predictor`: history shift register, saturating counter and `expect_z` register, with `clock`, `reset`, `enable`, `clear`, `bit_in`, `bit_valid` inputs.

## Test plan
- Reset held 2 cycles with `start`=1 -> all outputs 0, state IDLE; after release, `start` launches normally.
- pattern=16'h000F, length=8, repeat_n=0, start at N -> `w`=1,1,1,1,0,0,0,0 in N+1..N+8; `expect_z`=1 in N+5 and N+9 only; `done` in N+9.
- pattern=3'b101, length=3, repeat_n=2 -> `w`=1,0,1,1,0,1,1,0,1 in N+1..N+9; `expect_z` never 1; `done` in N+10.
- pattern=16'h0000, length=6, with `enable`=0 for 3 cycles after bit 2 -> `w` and `expect_z` frozen during the stall; `expect_z`=1 from the 4th-bit-plus-one enabled cycle; `done` in N+10.
- length=0 -> `done` in N+1, `w_valid` never 1; `start` pulsed during SHIFT of a length-8 transfer -> ignored, bit sequence unchanged.
- Reset asserted at bit 3 of a length-8 transfer -> IDLE next cycle, `busy`/`w_valid`/`expect_z`=0, no `done` pulse.

Source files
------------

// File: rtl/run_gen_pkg.sv
// Shared types, constants and helpers for the run-of-four test-pattern generator.
package run_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } gen_state_t;

  localparam int RUN_LEN   = 4;
  localparam int RUN_CNT_W = $clog2(RUN_LEN + 1);

  // True when every bit of the history window holds the same value.
  function automatic logic run_uniform(input logic [RUN_LEN-1:0] hist);
    return (&hist) | ~(|hist);
  endfunction

endpackage

// File: rtl/run_predictor.sv
// Predicts the run-of-four detector's Moore z output from the bits already sent:
// a RUN_LEN-bit history, a saturating bit count and a registered prediction.
module run_predictor
  import run_gen_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  input  logic bit_in,
  input  logic bit_valid,
  output logic expect_z
);

  logic [RUN_LEN-1:0]   hist_r;
  logic [RUN_LEN-1:0]   hist_s;
  logic [RUN_CNT_W-1:0] cnt_r;
  logic [RUN_CNT_W-1:0] cnt_s;
  logic                 expect_r;
  logic                 expect_s;

  // Next history/count; the prediction looks at the updated window so it lands one cycle after the bit.
  always_comb begin
    hist_s = hist_r;
    cnt_s  = cnt_r;
    if (clear) begin
      hist_s = {RUN_LEN{1'b0}};
      cnt_s  = {RUN_CNT_W{1'b0}};
    end else if (bit_valid) begin
      hist_s = {hist_r[RUN_LEN-2:0], bit_in};
      if (cnt_r == RUN_CNT_W'(RUN_LEN)) begin
        cnt_s = cnt_r;
      end else begin
        cnt_s = cnt_r + RUN_CNT_W'(1'b1);
      end
    end else begin
      hist_s = hist_r;
      cnt_s  = cnt_r;
    end
    expect_s = (cnt_s == RUN_CNT_W'(RUN_LEN)) && run_uniform(hist_s);
  end

  // Predictor state; enable low freezes everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      hist_r   <= {RUN_LEN{1'b0}};
      cnt_r    <= {RUN_CNT_W{1'b0}};
      expect_r <= 1'b0;
    end else if (enable) begin
      hist_r   <= hist_s;
      cnt_r    <= cnt_s;
      expect_r <= expect_s;
    end
  end

  assign expect_z = expect_r;

endmodule

// File: rtl/run_pattern_gen.sv
// Serial LSB-first pattern transmitter with repeat count, start/busy/done handshake
// and a cycle-aligned prediction of the run-of-four detector output.
module run_pattern_gen
  import run_gen_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int REPEAT_W = 4,
  parameter int LEN_W    = $clog2(WIDTH + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                start,
  input  logic [WIDTH-1:0]    pattern,
  input  logic [LEN_W-1:0]    length,
  input  logic [REPEAT_W-1:0] repeat_n,
  output logic                w,
  output logic                w_valid,
  output logic                busy,
  output logic                done,
  output logic                expect_z
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  gen_state_t          state_r;
  gen_state_t          state_s;
  logic [IDX_W-1:0]    idx_r;
  logic [IDX_W-1:0]    idx_s;
  logic [REPEAT_W-1:0] rep_r;
  logic [REPEAT_W-1:0] rep_s;
  logic [WIDTH-1:0]    pat_r;
  logic [WIDTH-1:0]    pat_s;
  logic [LEN_W-1:0]    len_r;
  logic [LEN_W-1:0]    len_s;
  logic [LEN_W-1:0]    len_clamp_s;
  logic                last_bit_s;

  logic w_r;
  logic w_s;
  logic w_valid_r;
  logic w_valid_s;
  logic busy_r;
  logic busy_s;
  logic done_r;
  logic done_s;
  logic pred_clear_s;

  // Length clamp and end-of-pass detection.
  always_comb begin
    if (length > LEN_W'(WIDTH)) begin
      len_clamp_s = LEN_W'(WIDTH);
    end else begin
      len_clamp_s = length;
    end
    last_bit_s = (LEN_W'(idx_r) == (len_r - LEN_W'(1'b1)));
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= IDLE;
      idx_r     <= {IDX_W{1'b0}};
      rep_r     <= {REPEAT_W{1'b0}};
      pat_r     <= {WIDTH{1'b0}};
      len_r     <= {LEN_W{1'b0}};
      w_r       <= 1'b0;
      w_valid_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else if (enable) begin
      state_r   <= state_s;
      idx_r     <= idx_s;
      rep_r     <= rep_s;
      pat_r     <= pat_s;
      len_r     <= len_s;
      w_r       <= w_s;
      w_valid_r <= w_valid_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    rep_s   = rep_r;
    pat_s   = pat_r;
    len_s   = len_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (len_clamp_s != {LEN_W{1'b0}}) begin
            state_s = SHIFT;
            idx_s   = {IDX_W{1'b0}};
            rep_s   = repeat_n;
            pat_s   = pattern;
            len_s   = len_clamp_s;
          end else begin
            state_s = DONE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (!last_bit_s) begin
          idx_s = idx_r + IDX_W'(1'b1);
        end else if (rep_r != {REPEAT_W{1'b0}}) begin
          rep_s = rep_r - REPEAT_W'(1'b1);
          idx_s = {IDX_W{1'b0}};
        end else begin
          state_s = DONE;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Outputs decoded from the next state so they register aligned with it.
  always_comb begin
    w_s       = 1'b0;
    w_valid_s = 1'b0;
    busy_s    = 1'b0;
    done_s    = 1'b0;
    case (state_s)
      SHIFT: begin
        w_s       = pat_s[idx_s];
        w_valid_s = 1'b1;
        busy_s    = 1'b1;
      end
      DONE: begin
        done_s = 1'b1;
      end
      IDLE: begin
        done_s = 1'b0;
      end
      default: begin
        done_s = 1'b0;
      end
    endcase
  end

  // Clearing outside SHIFT also zeroes the prediction for the IDLE cycle after DONE.
  assign pred_clear_s = (state_r != SHIFT);

  run_predictor u_pred (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .clear    (pred_clear_s),
    .bit_in   (w_r),
    .bit_valid(w_valid_r),
    .expect_z (expect_z)
  );

  assign w       = w_r;
  assign w_valid = w_valid_r;
  assign busy    = busy_r;
  assign done    = done_r;

endmodule
